// File: rtl/mac_job_scheduler.sv
// Round-robin scheduler sharing one 8x8 MAC datapath among NUM_REQ requesters.
// Optional build macro MAC_SAT_EN: saturating accumulation instead of wrap-around.
module mac_job_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 8,
  parameter int ID_W       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] job_len,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [7:0]               op_a,
  input  logic [7:0]               op_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_WIDTH-1:0]    res_data,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]                        state;
  logic [ID_W-1:0]                   ptr;
  logic [ID_W-1:0]                   id;
  logic [LEN_W-1:0]                  cnt;
  logic [DATA_WIDTH-1:0]             acc;
  logic [DATA_WIDTH-1:0]             prod;
  logic                              prod_valid;

  logic [NUM_REQ-1:0][LEN_W-1:0]     len_arr;
  logic [ID_W-1:0]                   sel_id;
  logic                              sel_found;
  logic [31:0]                       idx;
  logic [ID_W-1:0]                   cand;
  logic [15:0]                       mul;
  logic [DATA_WIDTH:0]               sum;
  logic [DATA_WIDTH-1:0]             acc_next;

  assign len_arr = job_len;
  assign mul     = op_a * op_b;
  assign sum     = {1'b0, acc} + {1'b0, prod};

`ifdef MAC_SAT_EN
  assign acc_next = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
`else
  assign acc_next = sum[DATA_WIDTH-1:0];
`endif

  // First requesting id at or above the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx  = (32'(ptr) + k) % NUM_REQ;
      cand = idx[ID_W-1:0];
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign op_ready  = (state == S_STREAM);
  assign res_valid = (state == S_RESULT);
  assign busy      = (state != S_IDLE);
  assign res_data  = acc;
  assign res_id    = id;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      id         <= '0;
      cnt        <= '0;
      acc        <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      gnt        <= '0;
    end else begin
      // Products land in the accumulator one cycle after their beat; a job
      // start below overrides this with a clear.
      if (prod_valid)
        acc <= acc_next;
      prod_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (sel_found) begin
            id  <= sel_id;
            gnt <= NUM_REQ'(1) << sel_id;
            acc <= '0;
            cnt <= len_arr[sel_id];
            if (len_arr[sel_id] == '0)
              state <= S_RESULT;
            else
              state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (op_valid) begin
            prod       <= DATA_WIDTH'(mul);
            prod_valid <= 1'b1;
            cnt        <= cnt - 1'b1;
            if (cnt == LEN_W'(1))
              state <= S_DRAIN;
          end
        end
        S_DRAIN: state <= S_RESULT;
        S_RESULT: begin
          if (res_ready) begin
            gnt   <= '0;
            ptr   <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Directed bench for mac_job_scheduler: single job, overflow, round-robin,
// zero length, backpressure and mid-job reset.
module tb_mac_job_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] job_len;
  logic [3:0]  gnt;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_id;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  mac_job_scheduler #(.NUM_REQ(4), .DATA_WIDTH(16), .LEN_W(8), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req(req), .job_len(job_len), .gnt(gnt),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; job_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt got %b exp %b", gnt, 4'b0000); end
    vectors++; if (op_ready !== 1'b0) begin miscompares++; $display("FAIL reset_op_ready got %b exp 0", op_ready); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (res_data !== 16'h0) begin miscompares++; $display("FAIL reset_res_data got %h exp 0000", res_data); end
    vectors++; if (res_id !== 2'd0) begin miscompares++; $display("FAIL reset_res_id got %0d exp 0", res_id); end
  endtask

  task automatic test_single_job;
    req = 4'b0001; job_len[7:0] = 8'd3;
    tick;
    req = '0;
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL single_gnt got %b exp 0001", gnt); end
    vectors++; if (op_ready !== 1'b1) begin miscompares++; $display("FAIL single_op_ready got %b exp 1", op_ready); end
    op_valid = 1'b1; op_a = 8'd2; op_b = 8'd3; tick;
    op_a = 8'd4; op_b = 8'd5; tick;
    op_a = 8'd6; op_b = 8'd7; tick;
    op_valid = 1'b0;
    vectors++; if (op_ready !== 1'b0) begin miscompares++; $display("FAIL single_drain_op_ready got %b exp 0", op_ready); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_res_valid got %b exp 0", res_valid); end
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL single_drain_gnt got %b exp 0001", gnt); end
    tick;
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL single_res_valid got %b exp 1", res_valid); end
    vectors++; if (res_data !== 16'd68) begin miscompares++; $display("FAIL single_res_data got %0d exp 68", res_data); end
    vectors++; if (res_id !== 2'd0) begin miscompares++; $display("FAIL single_res_id got %0d exp 0", res_id); end
    res_ready = 1'b1; tick; res_ready = 1'b0;
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL single_post_res_valid got %b exp 0", res_valid); end
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL single_post_gnt got %b exp 0000", gnt); end
  endtask

  task automatic test_overflow;
    logic [15:0] exp_sum;
`ifdef MAC_SAT_EN
    exp_sum = 16'hFFFF;
`else
    exp_sum = 16'hFC02;
`endif
    req = 4'b0001; job_len[7:0] = 8'd2;
    tick;
    req = '0;
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL ovf_gnt got %b exp 0001", gnt); end
    op_valid = 1'b1; op_a = 8'd255; op_b = 8'd255; tick; tick;
    op_valid = 1'b0;
    tick;
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_res_valid got %b exp 1", res_valid); end
    vectors++; if (res_data !== exp_sum) begin miscompares++; $display("FAIL ovf_res_data got %h exp %h", res_data, exp_sum); end
    res_ready = 1'b1; tick; res_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_gnt;
    int w;
    reset = 1'b1; tick; reset = 1'b0;
    req = 4'b1111; job_len = 32'h01010101;
    op_valid = 1'b1; op_a = 8'd1; op_b = 8'd1; res_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      exp_gnt = 4'b0001 << (j % 4);
      w = 0;
      while (gnt === 4'b0000 && w < 20) begin tick; w++; end
      vectors++; if (gnt !== exp_gnt) begin miscompares++; $display("FAIL rr_gnt[%0d] got %b exp %b", j, gnt, exp_gnt); end
      w = 0;
      while (res_valid !== 1'b1 && w < 20) begin tick; w++; end
      vectors++; if (res_id !== 2'(j % 4)) begin miscompares++; $display("FAIL rr_res_id[%0d] got %0d exp %0d", j, res_id, j % 4); end
      vectors++; if (res_data !== 16'd1) begin miscompares++; $display("FAIL rr_res_data[%0d] got %0d exp 1", j, res_data); end
      tick;
      vectors++; if (gnt !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("FAIL rr_gap[%0d] got gnt=%b busy=%b exp gnt=0000 busy=0", j, gnt, busy); end
    end
    req = '0; op_valid = 1'b0; res_ready = 1'b0;
  endtask

  task automatic test_zero_len;
    req = 4'b0100; job_len[23:16] = 8'd0;
    tick;
    req = '0;
    vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL zl_gnt got %b exp 0100", gnt); end
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL zl_res_valid got %b exp 1", res_valid); end
    vectors++; if (res_data !== 16'd0) begin miscompares++; $display("FAIL zl_res_data got %0d exp 0", res_data); end
    vectors++; if (res_id !== 2'd2) begin miscompares++; $display("FAIL zl_res_id got %0d exp 2", res_id); end
    for (int i = 0; i < 2; i++) begin
      vectors++; if (op_ready !== 1'b0) begin miscompares++; $display("FAIL zl_op_ready[%0d] got %b exp 0", i, op_ready); end
      tick;
    end
    vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL zl_hold_gnt got %b exp 0100", gnt); end
    res_ready = 1'b1; tick; res_ready = 1'b0;
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL zl_post_gnt got %b exp 0000", gnt); end
  endtask

  task automatic test_backpressure;
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    int p, cyc;
    logic accept;
    pa[0] = 8'd1; pa[1] = 8'd3; pa[2] = 8'd5; pa[3] = 8'd7;
    pb[0] = 8'd2; pb[1] = 8'd4; pb[2] = 8'd6; pb[3] = 8'd8;
    req = 4'b1000; job_len[31:24] = 8'd4;
    tick;
    vectors++; if (gnt !== 4'b1000) begin miscompares++; $display("FAIL bp_gnt got %b exp 1000", gnt); end
    req = 4'b1001; job_len[31:24] = 8'd9;
    p = 0; cyc = 0;
    while (p < 4 && cyc < 40) begin
      op_valid = (cyc % 2 == 0);
      op_a = pa[p]; op_b = pb[p];
      accept = op_valid && op_ready;
      tick;
      if (accept) p++;
      cyc++;
    end
    op_valid = 1'b0;
    vectors++; if (p !== 4) begin miscompares++; $display("FAIL bp_beats got %0d exp 4", p); end
    vectors++; if (gnt !== 4'b1000) begin miscompares++; $display("FAIL bp_stream_gnt got %b exp 1000", gnt); end
    tick;
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL bp_res_valid got %b exp 1", res_valid); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (res_data !== 16'd100 || res_valid !== 1'b1 || gnt !== 4'b1000) begin
        miscompares++;
        $display("FAIL bp_stall[%0d] got data=%0d valid=%b gnt=%b exp data=100 valid=1 gnt=1000", i, res_data, res_valid, gnt);
      end
      tick;
    end
    res_ready = 1'b1; tick; res_ready = 1'b0;
    vectors++; if (gnt !== 4'b0000 || res_valid !== 1'b0) begin miscompares++; $display("FAIL bp_post got gnt=%b valid=%b exp gnt=0000 valid=0", gnt, res_valid); end
    tick;
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL bp_next_gnt got %b exp 0001", gnt); end
    req = '0;
  endtask

  task automatic test_reset_mid_stream;
    reset = 1'b1; tick; reset = 1'b0;
    req = 4'b0001; job_len[7:0] = 8'd4;
    tick;
    req = '0;
    op_valid = 1'b1; op_a = 8'd3; op_b = 8'd3; tick; tick;
    op_valid = 1'b0;
    reset = 1'b1; tick; reset = 1'b0;
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rm_gnt got %b exp 0000", gnt); end
    vectors++; if (op_ready !== 1'b0) begin miscompares++; $display("FAIL rm_op_ready got %b exp 0", op_ready); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rm_res_valid got %b exp 0", res_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy got %b exp 0", busy); end
    vectors++; if (res_data !== 16'd0) begin miscompares++; $display("FAIL rm_res_data got %0d exp 0", res_data); end
    req = 4'b0110; job_len = 32'h00030300;
    tick;
    vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL rm_next_gnt got %b exp 0010", gnt); end
    vectors++; if (res_id !== 2'd1) begin miscompares++; $display("FAIL rm_next_id got %0d exp 1", res_id); end
    req = '0;
  endtask

  initial begin
    test_reset;
    test_single_job;
    test_overflow;
    test_round_robin;
    test_zero_len;
    test_backpressure;
    test_reset_mid_stream;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
